// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential reads, buffers returns, redirects on branch.
// Optional FETCH_QUEUE_PERF_EN adds a saturating stall_count output.
module fetch_queue #(
    parameter int ARQ = 16,
    parameter int MEMORY_ADDR_SIZE = 13,
    parameter int DEPTH = 4,
    parameter logic [MEMORY_ADDR_SIZE-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_rd,
    output logic [MEMORY_ADDR_SIZE-1:0] imem_addr,
    input  logic [ARQ-1:0]              imem_data,
    input  logic                        branch_taken,
    input  logic [MEMORY_ADDR_SIZE-1:0] jaddr,
    input  logic                        instr_ready,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [15:0]                 stall_count,
`endif
    output logic                        instr_valid,
    output logic [ARQ-1:0]              instr_out,
    output logic [MEMORY_ADDR_SIZE-1:0] pc_out
);

    localparam int PW = $clog2(DEPTH);

    logic [ARQ-1:0]              ins_mem [DEPTH];
    logic [MEMORY_ADDR_SIZE-1:0] pc_mem  [DEPTH];

    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [PW:0]                 count;
    logic                        inflight;
    logic [MEMORY_ADDR_SIZE-1:0] inflight_pc;
    logic [MEMORY_ADDR_SIZE-1:0] fetch_pc;

    logic                        has_room;
    logic                        issue;
    logic                        push;
    logic                        pop;

    // Credit counts the outstanding read but not a same-cycle pop.
    assign has_room = (32'(count) + 32'(inflight)) < 32'(DEPTH);
    assign issue    = !rst && !branch_taken && has_room;
    assign push     = inflight && !branch_taken;
    assign pop      = instr_valid && instr_ready && !branch_taken;

    assign imem_rd     = issue;
    assign imem_addr   = fetch_pc;
    assign instr_valid = !rst && (count != '0);
    assign instr_out   = instr_valid ? ins_mem[rd_ptr] : '0;
    assign pc_out      = instr_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ins_mem[wr_ptr] <= imem_data;
            pc_mem[wr_ptr]  <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_pc    <= RESET_PC;
        end else if (branch_taken) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fetch_pc <= jaddr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!instr_valid && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based model.
// Define FETCH_QUEUE_PERF_EN to also check stall_count.
module tb_fetch_queue;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_rd;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          branch_taken;
    logic [AW-1:0] jaddr;
    logic          instr_ready;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] pc_out;
`ifdef FETCH_QUEUE_PERF_EN
    logic [15:0]   stall_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .ARQ(DW),
        .MEMORY_ADDR_SIZE(AW),
        .DEPTH(DEPTH),
        .RESET_PC('0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_rd(imem_rd),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .branch_taken(branch_taken),
        .jaddr(jaddr),
        .instr_ready(instr_ready),
`ifdef FETCH_QUEUE_PERF_EN
        .stall_count(stall_count),
`endif
        .instr_valid(instr_valid),
        .instr_out(instr_out),
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {3'b000, a} + 16'h0100;
    endfunction

    // Memory answers one cycle after a read; junk otherwise.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem_word(imem_addr);
        else imem_data <= 16'($urandom);
    end

    typedef struct {
        logic [DW-1:0] ins;
        logic [AW-1:0] pc;
    } entry_t;

    entry_t        mq[$];
    logic [AW-1:0] m_pc = '0;
    bit            m_infl = 0;
    logic [AW-1:0] m_infl_pc = '0;
    logic [15:0]   m_stall = '0;

    logic          obs_rd;
    logic [AW-1:0] obs_addr;
    logic          obs_valid;
    logic [DW-1:0] obs_instr;
    logic [AW-1:0] obs_pc;
    logic [15:0]   obs_stall;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit b,
                        input logic [AW-1:0] j, input bit rdy);
        bit            e_valid;
        bit            e_rd;
        logic [DW-1:0] e_ins;
        logic [AW-1:0] e_pc;
        entry_t        ent;
        @(negedge clk);
        rst = r;
        branch_taken = b;
        jaddr = j;
        instr_ready = rdy;
        #1;
        e_valid = !r && (mq.size() != 0);
        e_ins = e_valid ? mq[0].ins : '0;
        e_pc = e_valid ? mq[0].pc : '0;
        e_rd = !r && !b && ((mq.size() + int'(m_infl)) < DEPTH);
        obs_rd = imem_rd;
        obs_addr = imem_addr;
        obs_valid = instr_valid;
        obs_instr = instr_out;
        obs_pc = pc_out;
        check("valid", 32'(instr_valid), 32'(e_valid));
        check("instr", 32'(instr_out), 32'(e_ins));
        check("pc", 32'(pc_out), 32'(e_pc));
        check("rd", 32'(imem_rd), 32'(e_rd));
        if (e_rd) check("addr", 32'(imem_addr), 32'(m_pc));
`ifdef FETCH_QUEUE_PERF_EN
        obs_stall = stall_count;
        check("stall", 32'(stall_count), 32'(m_stall));
`else
        obs_stall = '0;
`endif
        @(posedge clk);
        if (r) begin
            m_stall = '0;
        end else if (!e_valid && m_stall != 16'hFFFF) begin
            m_stall = m_stall + 16'd1;
        end
        if (r) begin
            mq.delete();
            m_infl = 0;
            m_pc = '0;
        end else if (b) begin
            mq.delete();
            m_infl = 0;
            m_pc = j;
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_infl) begin
                ent.ins = mem_word(m_infl_pc);
                ent.pc = m_infl_pc;
                mq.push_back(ent);
            end
            m_infl = e_rd;
            if (e_rd) begin
                m_infl_pc = m_pc;
                m_pc = m_pc + 1'b1;
            end
        end
    endtask

    int nrd;

    initial begin
        rst = 1'b1;
        branch_taken = 1'b0;
        jaddr = '0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        step(1, 0, '0, 0);
        step(1, 0, '0, 1);

        // Sequential streaming from reset.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0, 1);
            if (i == 0) check("first_addr", 32'(obs_addr), 32'h0);
            if (i == 2) check("first_instr", 32'(obs_instr), 32'h0100);
            if (i == 3) check("second_pc", 32'(obs_pc), 32'h1);
        end

        // Stall downstream: queue fills to DEPTH and stops.
        step(1, 0, '0, 0);
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, '0, 0);
            nrd += int'(obs_rd);
        end
        check("fill_reads", 32'(nrd), 32'd4);
        check("full_rd", 32'(obs_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 1);
            check("drain_pc", 32'(obs_pc), 32'(i));
        end

        // Branch with 3 queued and one in flight.
        step(1, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0);
        step(0, 1, 13'h0A0, 0);
        step(0, 0, '0, 0);
        check("br_valid", 32'(obs_valid), 32'd0);
        check("br_addr", 32'(obs_addr), 32'h0A0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        check("br_instr", 32'(obs_instr), 32'h01A0);
        check("br_pc", 32'(obs_pc), 32'h0A0);

        // Address wrap at the top of the space.
        step(0, 1, 13'h1FFE, 1);
        step(0, 0, '0, 1);
        check("wrap0", 32'(obs_addr), 32'h1FFE);
        step(0, 0, '0, 1);
        check("wrap1", 32'(obs_addr), 32'h1FFF);
        step(0, 0, '0, 1);
        check("wrap2", 32'(obs_addr), 32'h0000);

        // Reset beats a same-cycle branch on a full queue.
        for (int i = 0; i < 8; i++) step(0, 0, '0, 0);
        step(1, 1, 13'h055, 0);
        step(0, 0, '0, 0);
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_addr", 32'(obs_addr), 32'h0);

`ifdef FETCH_QUEUE_PERF_EN
        step(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, '0, 0);
        step(0, 0, '0, 1);
        check("stall5", 32'(obs_stall), 32'd5);
`endif

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) == 0,
                 AW'($urandom),
                 $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
